// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester/SRAM bus bundle for sram_arbiter
interface sram_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic              we0;
  logic              we1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  // master: both requesters plus the SRAM itself; slave: the arbiter
  modport master (
    output req0, req1, addr0, addr1, we0, we1, wdata0, wdata1, mem_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_we, mem_din
  );
  modport slave (
    input  req0, req1, addr0, addr1, we0, we1, wdata0, wdata1, mem_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-master single-port SRAM arbiter; SRAM_ARB_RR_EN selects round-robin, else fixed priority
module sram_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input logic           clk,
  input logic           reset,
  sram_arbiter_if.slave bus
);

  logic                elig0;
  logic                elig1;
  logic                pick1;
  logic                out_v;
  logic [READ_LAT-1:0] rd_v;
  logic [READ_LAT-1:0] rd_p;
  logic [DATA_W-1:0]   rdata_q;

  // A port is never eligible in its own grant cycle, which rate-limits each master
  assign elig0 = bus.req0 & ~bus.gnt0;
  assign elig1 = bus.req1 & ~bus.gnt1;

`ifdef SRAM_ARB_RR_EN
  logic last1;

  always_comb begin
    pick1 = elig1 & (~elig0 | ~last1);
  end
`else
  always_comb begin
    pick1 = elig1 & ~elig0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.gnt0     <= 1'b0;
      bus.gnt1     <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
      rd_v         <= '0;
      rd_p         <= '0;
      rdata_q      <= '0;
`ifdef SRAM_ARB_RR_EN
      last1        <= 1'b1;
`endif
    end else begin
      bus.gnt0 <= elig0 & ~pick1;
      bus.gnt1 <= pick1;
      if (elig0 | elig1) begin
        bus.mem_we   <= pick1 ? bus.we1    : bus.we0;
        bus.mem_addr <= pick1 ? bus.addr1  : bus.addr0;
        bus.mem_din  <= pick1 ? bus.wdata1 : bus.wdata0;
`ifdef SRAM_ARB_RR_EN
        last1        <= pick1;
`endif
      end else begin
        bus.mem_we <= 1'b0;
      end
      // Tag the access currently on the bus; only reads produce a return slot
      rd_v[0] <= (bus.gnt0 | bus.gnt1) & ~bus.mem_we;
      rd_p[0] <= bus.gnt1;
      for (int i = READ_LAT - 1; i > 0; i--) begin
        rd_v[i] <= rd_v[i-1];
        rd_p[i] <= rd_p[i-1];
      end
      rdata_q <= bus.rdata;
    end
  end

  // Gating with reset discards a return that would otherwise exit during reset
  assign out_v       = rd_v[READ_LAT-1] & ~reset;
  assign bus.rvalid0 = out_v & ~rd_p[READ_LAT-1];
  assign bus.rvalid1 = out_v &  rd_p[READ_LAT-1];
  assign bus.rdata   = out_v ? bus.mem_dout : rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench running READ_LAT=1 and READ_LAT=3 arbiters in lockstep
module tb_sram_arbiter;

`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        r0;
    logic        w0;
    logic [11:0] a0;
    logic [15:0] d0;
    logic        r1;
    logic        w1;
    logic [11:0] a1;
    logic [15:0] d1;
    logic        e0;
    logic        e1;
  } vec_t;

  typedef struct {
    bit        port;
    bit [15:0] data;
    int        cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [11:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit   [15:0] ref_mem [4096];
  bit   [15:0] ram1 [4096];
  bit   [15:0] ram3 [4096];
  logic [15:0] d1;
  logic [15:0] d3 [3];
  exp_t        q1 [$];
  exp_t        q3 [$];
  bit   [15:0] last1 = '0, last3 = '0;
  vec_t        tbl [$];

  sram_arbiter_if #(.ADDR_W(12), .DATA_W(16)) b1 ();
  sram_arbiter_if #(.ADDR_W(12), .DATA_W(16)) b3 ();

  sram_arbiter #(.ADDR_W(12), .DATA_W(16), .READ_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave));
  sram_arbiter #(.ADDR_W(12), .DATA_W(16), .READ_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .bus(b3.slave));

  assign b1.req0 = req0;   assign b3.req0 = req0;
  assign b1.req1 = req1;   assign b3.req1 = req1;
  assign b1.we0 = we0;     assign b3.we0 = we0;
  assign b1.we1 = we1;     assign b3.we1 = we1;
  assign b1.addr0 = addr0; assign b3.addr0 = addr0;
  assign b1.addr1 = addr1; assign b3.addr1 = addr1;
  assign b1.wdata0 = wdata0; assign b3.wdata0 = wdata0;
  assign b1.wdata1 = wdata1; assign b3.wdata1 = wdata1;
  assign b1.mem_dout = d1;
  assign b3.mem_dout = d3[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous SRAM models: read data READ_LAT clocks after the access cycle
  always @(posedge clk) begin
    if (b1.mem_we) ram1[b1.mem_addr] <= b1.mem_din;
    d1 <= ram1[b1.mem_addr];
    if (b3.mem_we) ram3[b3.mem_addr] <= b3.mem_din;
    d3[0] <= ram3[b3.mem_addr];
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(logic r0, logic w0, logic [11:0] a0, logic [15:0] dd0,
                              logic r1, logic w1, logic [11:0] a1, logic [15:0] dd1,
                              logic e0, logic e1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = dd0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = dd1;
    v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic chk_dut(string tag, logic g0, logic g1, logic we, logic [11:0] ma,
                         logic [15:0] md, vec_t v);
    chk({tag, " gnt0"}, g0, v.e0);
    chk({tag, " gnt1"}, g1, v.e1);
    if (v.e0 || v.e1) begin
      chk({tag, " mem_we"}, we, v.e1 ? v.w1 : v.w0);
      chk({tag, " mem_addr"}, ma, v.e1 ? v.a1 : v.a0);
      if (v.e1 ? v.w1 : v.w0) chk({tag, " mem_din"}, md, v.e1 ? v.d1 : v.d0);
    end else begin
      chk({tag, " idle mem_we"}, we, 1'b0);
    end
  endtask

  task automatic push_rd(bit port, bit [11:0] a);
    exp_t e;
    e.port = port;
    e.data = ref_mem[a];
    e.cyc  = cyc + 1;
    q1.push_back(e);
    e.cyc  = cyc + 3;
    q3.push_back(e);
  endtask

  task automatic apply_row(vec_t v);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    @(posedge clk);
    #1;
    chk_dut("L1", b1.gnt0, b1.gnt1, b1.mem_we, b1.mem_addr, b1.mem_din, v);
    chk_dut("L3", b3.gnt0, b3.gnt1, b3.mem_we, b3.mem_addr, b3.mem_din, v);
    if (v.e0 || v.e1) begin
      if (v.e1 ? v.w1 : v.w0) ref_mem[v.e1 ? v.a1 : v.a0] = v.e1 ? v.d1 : v.d0;
      else push_rd(v.e1, v.e1 ? v.a1 : v.a0);
    end
  endtask

  task automatic chk_zero(string tag, logic g0, logic g1, logic rv0, logic rv1, logic we,
                          logic [11:0] ma, logic [15:0] md, logic [15:0] rd);
    chk({tag, " gnt0=0"}, g0, 0);
    chk({tag, " gnt1=0"}, g1, 0);
    chk({tag, " rvalid0=0"}, rv0, 0);
    chk({tag, " rvalid1=0"}, rv1, 0);
    chk({tag, " mem_we=0"}, we, 0);
    chk({tag, " mem_addr=0"}, ma, 0);
    chk({tag, " mem_din=0"}, md, 0);
    chk({tag, " rdata=0"}, rd, 0);
  endtask

  // Scoreboard: every rvalid must match the oldest outstanding read
  always @(negedge clk) begin
    if (b1.rvalid0 || b1.rvalid1) begin
      chk("L1 rvalid onehot", b1.rvalid0 & b1.rvalid1, 0);
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL L1 unexpected rvalid: got rvalid0=%0b rvalid1=%0b want none (cycle %0d)",
                 b1.rvalid0, b1.rvalid1, cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("L1 rvalid port", b1.rvalid1, e.port);
        chk("L1 rdata", b1.rdata, e.data);
        chk("L1 rvalid cycle", cyc, e.cyc);
        last1 = e.data;
      end
    end
    if (b3.rvalid0 || b3.rvalid1) begin
      chk("L3 rvalid onehot", b3.rvalid0 & b3.rvalid1, 0);
      if (q3.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL L3 unexpected rvalid: got rvalid0=%0b rvalid1=%0b want none (cycle %0d)",
                 b3.rvalid0, b3.rvalid1, cyc);
      end else begin
        exp_t e;
        e = q3.pop_front();
        chk("L3 rvalid port", b3.rvalid1, e.port);
        chk("L3 rdata", b3.rdata, e.data);
        chk("L3 rvalid cycle", cyc, e.cyc);
        last3 = e.data;
      end
    end
  end

  initial begin
    // write 99, read it back, then seed 100/200
    tbl.push_back(mk(1, 1, 12'd99, 16'h00AB, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 12'd99, 16'h00AB, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 12'd99, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 12'd99, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 12'd100, 16'h1111, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 12'd100, 16'h1111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 12'd200, 16'h2222, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 12'd200, 16'h2222, 0, 0));
    // both ports reading continuously: strict alternation starting at port 0
    tbl.push_back(mk(1, 0, 12'd100, 0, 1, 0, 12'd200, 0, 1, 0));
    tbl.push_back(mk(1, 0, 12'd100, 0, 1, 0, 12'd200, 0, 0, 1));
    tbl.push_back(mk(1, 0, 12'd100, 0, 1, 0, 12'd200, 0, 1, 0));
    tbl.push_back(mk(1, 0, 12'd100, 0, 1, 0, 12'd200, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // tie right after a port-0 grant: mode decides the winner
    tbl.push_back(mk(1, 0, 12'd99, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 12'd99, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 12'd100, 0, 1, 0, 12'd99, 0, !RR, RR));
    tbl.push_back(mk(1, 0, 12'd100, 0, 1, 0, 12'd99, 0, RR, !RR));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // port 0 back-to-back, port 1 arrives late
    tbl.push_back(mk(1, 0, 12'd200, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 12'd200, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 12'd200, 0, 1, 0, 12'd100, 0, !RR, RR));
    tbl.push_back(mk(1, 0, 12'd200, 0, 1, 0, 12'd100, 0, RR, !RR));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    chk_zero("L1 reset", b1.gnt0, b1.gnt1, b1.rvalid0, b1.rvalid1, b1.mem_we,
             b1.mem_addr, b1.mem_din, b1.rdata);
    chk_zero("L3 reset", b3.gnt0, b3.gnt1, b3.rvalid0, b3.rvalid1, b3.mem_we,
             b3.mem_addr, b3.mem_din, b3.rdata);
    reset = 1'b0;

    foreach (tbl[i]) apply_row(tbl[i]);

    chk("L1 drained", q1.size(), 0);
    chk("L3 drained", q3.size(), 0);
    chk("L1 rdata hold", b1.rdata, last1);
    chk("L3 rdata hold", b3.rdata, last3);

    // port 1 read granted, then reset lands in the following cycle
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 12'd100;
    @(posedge clk);
    #1;
    chk("L1 pre-reset gnt1", b1.gnt1, 1);
    chk("L3 pre-reset gnt1", b3.gnt1, 1);
    reset = 1'b1; req1 = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("L1 midreset", b1.gnt0, b1.gnt1, b1.rvalid0, b1.rvalid1, b1.mem_we,
             b1.mem_addr, b1.mem_din, b1.rdata);
    chk_zero("L3 midreset", b3.gnt0, b3.gnt1, b3.rvalid0, b3.rvalid1, b3.mem_we,
             b3.mem_addr, b3.mem_din, b3.rdata);
    reset = 1'b0;
    apply_row(mk(1, 0, 12'd99, 0, 1, 0, 12'd200, 0, 1, 0));
    apply_row(mk(1, 0, 12'd99, 0, 1, 0, 12'd200, 0, 0, 1));
    for (int i = 0; i < 5; i++) apply_row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    chk("L1 final drained", q1.size(), 0);
    chk("L3 final drained", q3.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
